multi_debouncer: RTL
====================

Name: multi_debouncer

Overview:
- Parametrised N-channel push-button conditioner. Successor to the single-button, press-only debouncer.
- Per channel it provides:
  - 2-flop input synchroniser.
  - Symmetric debounce on both press and release.
  - Registered one-cycle press and release pulses.
  - Optional long-press auto-repeat pulse.
- Sits between board buttons and the vending FSM (coin/select/cancel keys), so the FSM sees only clean, single-cycle events.

Parameters:
- N_CH, 5: number of button channels.
- DEBOUNCE_CYC, 1000000: consecutive stable cycles needed to accept a level change (10 ms at 100 MHz); must be >= 2.
- HOLD_CYC, 50000000: cycles from the press pulse to the first repeat pulse (0.5 s).
- REPEAT_CYC, 10000000: cycles between subsequent repeat pulses while held (100 ms).
- REPEAT_EN, 1: 1 = auto-repeat enabled; 0 = repeat_o never asserts.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous active-high reset.
- btn_in, input, N_CH: raw asynchronous button levels, active-high.
- clean_o, output, N_CH: debounced level per channel.
- press_o, output, N_CH: one-cycle pulse on an accepted 0->1 transition.
- release_o, output, N_CH: one-cycle pulse on an accepted 1->0 transition.
- repeat_o, output, N_CH: one-cycle pulse at long-press and at each auto-repeat interval.

Behaviour:
- Reset (async assert, sync deassert by system):
  - All synchroniser flops, counters, clean_o, press_o, release_o and repeat_o go to 0.
  - A reset mid-count discards progress. A button held through reset produces a fresh press after full debounce once reset drops.
- Synchroniser: sync0 <= btn_in; sync1 <= sync0. All later logic uses sync1 only.
- Debounce, per channel, with counter db_cnt of width $clog2(DEBOUNCE_CYC):
  - If sync1 == clean: db_cnt <= 0.
  - Else if db_cnt == DEBOUNCE_CYC-1: clean <= sync1, db_cnt <= 0.
  - Else: db_cnt <= db_cnt+1.
  - Any single-cycle bounce back to the current clean value restarts the count from zero.
- Latency: if btn_in changes before edge k and then stays stable, clean_o changes at edge k+1+DEBOUNCE_CYC. This applies to both press and release.
- Event pulses:
  - press_o[i] is registered and asserts at the same edge clean_o[i] rises, for exactly 1 cycle.
  - release_o[i] behaves the same way on the falling edge of clean_o[i].
  - press and release can never be asserted together on one channel.
- Repeat logic, per channel, with counter hold_cnt sized for max(HOLD_CYC, REPEAT_CYC):
  - hold_cnt is cleared while clean=0 and at the press edge. It increments while clean=1.
  - With the press at edge p, repeat_o asserts at edge p+HOLD_CYC. hold_cnt then reloads, and repeat_o asserts every REPEAT_CYC edges after that while clean stays 1.
  - Release cancels repeat immediately. If release and a repeat fall due at the same edge, release wins and repeat_o stays 0.
- Counter widths must hold the maximum terminal count without wrap. Counters never wrap during normal operation.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses, with no arbitration.
- No combinational path from btn_in to any output.

Decomposition:
- Package mdb_pkg holds:
  - Default timing constants DEBOUNCE_CYC_DEF, HOLD_CYC_DEF, REPEAT_CYC_DEF.
  - CLK_HZ.
  - A function that returns the counter width for a cycle count.
- Sub-module debounce_channel holds the full single-channel path (synchroniser, debounce counter, event and repeat logic) and has the same parameters minus N_CH.
- multi_debouncer is a generate loop of N_CH debounce_channel instances.

Test Plan (bench params: N_CH=2, DEBOUNCE_CYC=4, HOLD_CYC=10, REPEAT_CYC=3):
- Clean press: btn_in[0] 0->1 before edge k, held -> clean_o[0] and press_o[0] rise at edge k+5; press_o[0] high for 1 cycle; channel 1 outputs stay 0.
- Bounce: btn_in[0] pattern 1,1,0,1,1,1,1 (one value per cycle) -> counter restarts after the 0; clean_o[0] rises 5 edges after the last 0->1 and press_o fires once only.
- Release: after a stable press, drop btn_in[0] -> clean_o[0] falls and release_o[0] pulses 1 cycle at edge k+5; no repeat_o afterwards.
- Long press: hold btn_in[1] -> press at edge p; repeat_o[1] pulses at p+10, p+13 and p+16; releasing at an edge where a repeat is due gives release_o[1]=1 and repeat_o[1]=0. Rerun with REPEAT_EN=0 -> repeat_o stays 0.
- Simultaneous: both channels pressed in the same cycle -> press_o=2'b11 at the same edge.
- Reset mid-debounce: assert rst while db_cnt=2 -> all outputs 0 immediately, asynchronously. With the button held, deassert rst -> press arrives a full 5 edges after deassertion.

Source files
------------

// File: rtl/multi_debouncer_pkg.sv
// Shared timing defaults and counter sizing helper for the push-button conditioner.
package mdb_pkg;

    localparam int unsigned CLK_HZ           = 100_000_000;
    localparam int unsigned DEBOUNCE_CYC_DEF = CLK_HZ / 100;  // 10 ms
    localparam int unsigned HOLD_CYC_DEF     = CLK_HZ / 2;    // 0.5 s
    localparam int unsigned REPEAT_CYC_DEF   = CLK_HZ / 10;   // 100 ms

    // Bits needed for a counter that runs 0 .. cycles-1 without wrapping.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/multi_debouncer_channel.sv
// Single-button path: synchroniser, symmetric debounce, press/release pulses
// and optional long-press auto-repeat.
module debounce_channel
    import mdb_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int unsigned HOLD_CYC     = HOLD_CYC_DEF,
    parameter int unsigned REPEAT_CYC   = REPEAT_CYC_DEF,
    parameter bit          REPEAT_EN    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic clean_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam int unsigned DW   = cnt_width(DEBOUNCE_CYC);
    localparam int unsigned HMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int unsigned HW   = cnt_width(HMAX);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYC - 1);

    logic          r_sync0;
    logic          r_sync1;
    logic [DW-1:0] r_db_cnt;
    logic          r_clean;
    logic          r_press;
    logic          r_release;
    logic          r_repeat;
    logic [HW-1:0] r_hold_cnt;
    logic          r_rep_phase;   // 0: waiting for long-press, 1: in repeat cadence

    logic          w_db_done;
    logic          w_rise;
    logic          w_fall;
    logic [HW-1:0] w_hold_target;
    logic          w_rep_due;

    // An accepted level change happens when the differing level has lasted the full window.
    assign w_db_done     = (r_sync1 != r_clean) && (r_db_cnt == DB_LAST);
    assign w_rise        = w_db_done && !r_clean;
    assign w_fall        = w_db_done &&  r_clean;
    assign w_hold_target = r_rep_phase ? REP_LAST : HOLD_LAST;
    assign w_rep_due     = r_clean && (r_hold_cnt == w_hold_target);

    // Two-flop synchroniser; only r_sync1 is used downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
        end else begin
            r_sync0 <= btn_in;
            r_sync1 <= r_sync0;
        end
    end

    // Debounce counter: any cycle matching the clean level restarts the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_cnt <= '0;
            r_clean  <= 1'b0;
        end else if (r_sync1 == r_clean) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
            r_clean  <= r_sync1;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + DW'(1);
        end
    end

    // Press/release pulses land on the same edge as the clean level change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= w_rise;
            r_release <= w_fall;
        end
    end

    // Hold timer: first pulse after HOLD_CYC, then every REPEAT_CYC; a release edge suppresses a due pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_cnt  <= '0;
            r_rep_phase <= 1'b0;
            r_repeat    <= 1'b0;
        end else if (!r_clean || w_fall) begin
            r_hold_cnt  <= '0;
            r_rep_phase <= 1'b0;
            r_repeat    <= 1'b0;
        end else if (w_rep_due) begin
            r_hold_cnt  <= '0;
            r_rep_phase <= 1'b1;
            r_repeat    <= REPEAT_EN;
        end else begin
            r_hold_cnt  <= r_hold_cnt + HW'(1);
            r_repeat    <= 1'b0;
        end
    end

    assign clean_o   = r_clean;
    assign press_o   = r_press;
    assign release_o = r_release;
    assign repeat_o  = r_repeat;

endmodule

// File: rtl/multi_debouncer.sv
// N independent button channels feeding clean level and event pulses to the vending FSM.
module multi_debouncer
    import mdb_pkg::*;
#(
    parameter int unsigned N_CH         = 5,
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int unsigned HOLD_CYC     = HOLD_CYC_DEF,
    parameter int unsigned REPEAT_CYC   = REPEAT_CYC_DEF,
    parameter bit          REPEAT_EN    = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] clean_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] repeat_o
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .HOLD_CYC     (HOLD_CYC),
            .REPEAT_CYC   (REPEAT_CYC),
            .REPEAT_EN    (REPEAT_EN)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .btn_in    (btn_in[g]),
            .clean_o   (clean_o[g]),
            .press_o   (press_o[g]),
            .release_o (release_o[g]),
            .repeat_o  (repeat_o[g])
        );
    end

endmodule
